// File: rtl/pcm_tx_scheduler.sv
// Paces PCM samples from a small FIFO out at one sample per CLK_DIV cycles; pulse is registered (tick+1).
// Backpressure: in_ready low in IDLE or when full; underruns emit zeros and re-prime after sustained starvation.
module pcm_tx_scheduler #(
    parameter int CLK_DIV          = 3000,
    parameter int FIFO_DEPTH       = 8,
    parameter int PRIME_LEVEL      = 4,
    parameter int UNDERRUN_REPRIME = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        mute,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] pcm_out,
    output logic        audio_valid,
    output logic        running,
    output logic [7:0]  underrun_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int OW = AW + 1;
    localparam int CW = $clog2(CLK_DIV);
    localparam int UW = $clog2(UNDERRUN_REPRIME + 1);

    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

    state_t         state, state_nxt;
    logic [15:0]    mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [OW-1:0]  occ;
    logic [CW-1:0]  cnt;
    logic [UW-1:0]  consec;
    logic           full, empty, push, pop, tick, flush, reprime;

    assign full     = (occ == OW'(FIFO_DEPTH));
    assign empty    = (occ == '0);
    assign in_ready = (state != IDLE) && !full;
    assign push     = in_valid && in_ready;
    // A dropping enable suppresses the tick so no new pulse is launched while leaving RUN.
    assign tick     = (state == RUN) && enable && (cnt == CW'(CLK_DIV - 1));
    assign pop      = tick && !empty;
    assign reprime  = tick && empty && (consec == UW'(UNDERRUN_REPRIME - 1));
    assign flush    = !enable || (state == IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable) state_nxt = PRIME;
            PRIME:   if (!enable) state_nxt = IDLE;
                     else if (occ >= OW'(PRIME_LEVEL)) state_nxt = RUN;
            RUN:     if (!enable) state_nxt = IDLE;
                     else if (reprime) state_nxt = PRIME;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            running <= 1'b0;
        end else begin
            state   <= state_nxt;
            running <= (state_nxt == RUN);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            occ <= occ + OW'(push) - OW'(pop);
        end
    end

    // Counter idles at 0 outside RUN, so entering RUN always starts a full period.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                         cnt <= '0;
        else if (state != RUN)                cnt <= '0;
        else if (cnt == CW'(CLK_DIV - 1))     cnt <= '0;
        else                                  cnt <= cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            consec         <= '0;
            audio_valid    <= 1'b0;
            pcm_out        <= '0;
            underrun_count <= '0;
        end else begin
            audio_valid <= tick;
            if (tick) begin
                pcm_out <= (empty || mute) ? 16'h0000 : mem[rd_ptr];
                if (!empty || reprime) consec <= '0;
                else                   consec <= consec + 1'b1;
                if (empty && underrun_count != 8'hFF)
                    underrun_count <= underrun_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pcm_tx_scheduler.sv
// Scoreboard bench for pcm_tx_scheduler with CLK_DIV=8, FIFO_DEPTH=4, PRIME_LEVEL=2, UNDERRUN_REPRIME=3.
module tb_pcm_tx_scheduler;

    localparam int CLK_DIV = 8;
    localparam int DEPTH   = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        mute = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] pcm_out;
    logic        audio_valid;
    logic        running;
    logic [7:0]  underrun_count;

    pcm_tx_scheduler #(
        .CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH), .PRIME_LEVEL(2), .UNDERRUN_REPRIME(3)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .mute(mute),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .pcm_out(pcm_out), .audio_valid(audio_valid), .running(running),
        .underrun_count(underrun_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard: expected FIFO contents, filled from observed handshakes one cycle late
    // so a pulse is compared against what the FIFO held at its tick.
    logic [15:0] exp_q[$];
    int          pulse_cyc[$];
    int          pulse_cnt = 0;
    int          exp_under = 0;
    logic        have_pend = 1'b0;
    logic [15:0] pend = '0;
    logic        last_mute = 1'b0;

    always @(negedge clk) begin
        if (!reset_n) begin
            exp_q.delete();
            have_pend = 1'b0;
            exp_under = 0;
            last_mute = 1'b0;
        end else begin
            if (audio_valid) begin
                pulse_cnt++;
                pulse_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    if (exp_under < 255) exp_under++;
                    check("pcm_underrun", pcm_out, 0);
                    check("underrun_count", underrun_count, exp_under);
                end else begin
                    logic [15:0] e;
                    e = exp_q.pop_front();
                    check("pcm_data", pcm_out, last_mute ? 16'h0 : e);
                end
            end
            if (have_pend) exp_q.push_back(pend);
            have_pend = in_valid && in_ready;
            pend      = in_data;
            if (!enable) begin
                exp_q.delete();
                have_pend = 1'b0;
            end
            last_mute = mute;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_pulses(input int n, input int budget);
        int i;
        for (i = 0; i < budget && pulse_cnt < n; i++) step(1);
        if (pulse_cnt < n) check("timeout_pulses", pulse_cnt, n);
    endtask

    task automatic wait_under(input int n, input int budget);
        int i;
        for (i = 0; i < budget && exp_under < n; i++) step(1);
        if (exp_under < n) check("timeout_underrun", exp_under, n);
    endtask

    task automatic wait_av(input int budget);
        int i;
        for (i = 0; i < budget && !audio_valid; i++) step(1);
        if (!audio_valid) check("timeout_audio_valid", 0, 1);
    endtask

    task automatic push1(input logic [15:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step(1);
        in_valid = 1'b0;
    endtask

    initial begin
        int trans;
        int n;
        int occ;
        int k;
        logic acc;
        logic [7:0] uc0;

        // Reset state
        step(3);
        check("rst_audio_valid", audio_valid, 0);
        check("rst_pcm_out", pcm_out, 0);
        check("rst_running", running, 0);
        check("rst_underrun", underrun_count, 0);
        check("rst_in_ready", in_ready, 0);
        reset_n = 1'b1;
        step(2);
        check("idle_in_ready", in_ready, 0);

        // Prime and steady run
        enable = 1'b1;
        step(1);
        check("prime_in_ready", in_ready, 1);
        push1(16'h1111);
        push1(16'h2222);
        check("running_before", running, 0);
        push1(16'h3333);
        check("running_after", running, 1);
        trans = cyc - 1;
        wait_pulses(3, 80);
        if (pulse_cyc.size() >= 3) begin
            check("first_pulse_latency", pulse_cyc[0], trans + CLK_DIV + 1);
            check("pulse_spacing_1", pulse_cyc[1] - pulse_cyc[0], CLK_DIV);
            check("pulse_spacing_2", pulse_cyc[2] - pulse_cyc[1], CLK_DIV);
        end

        // Underrun and re-prime
        wait_under(3, 100);
        check("underrun_total", underrun_count, 3);
        check("reprime_running", running, 0);
        check("reprime_in_ready", in_ready, 1);
        n = pulse_cnt;
        step(30);
        check("no_pulse_in_prime", pulse_cnt, n);

        // Full FIFO with in_valid held high
        occ = 0;
        k = 0;
        in_valid = 1'b1;
        in_data  = 16'h0100;
        for (int c = 0; c < 60; c++) begin
            if (audio_valid) occ--;
            check("in_ready_full", in_ready, (occ < DEPTH) ? 1 : 0);
            acc = in_ready;
            if (acc) occ++;
            step(1);
            if (acc) begin
                k++;
                in_data = 16'h0100 + 16'(k);
            end
        end
        in_valid = 1'b0;

        // Mute
        enable = 1'b0;
        step(2);
        check("disabled_running", running, 0);
        check("disabled_in_ready", in_ready, 0);
        enable = 1'b1;
        step(1);
        push1(16'h7FFF);
        push1(16'h1234);
        push1(16'hAAAA);
        push1(16'hBBBB);
        mute = 1'b1;
        uc0 = underrun_count;
        wait_av(40);
        mute = 1'b0;
        check("mute_underrun_unchanged", underrun_count, uc0);
        push1(16'hCCCC);
        n = pulse_cnt;
        wait_pulses(n + 1, 40);

        // Disable mid-run with three entries queued
        enable = 1'b0;
        step(1);
        check("disable_running", running, 0);
        check("disable_in_ready", in_ready, 0);
        n = pulse_cnt;
        step(20);
        check("disable_no_pulse", pulse_cnt, n);
        enable = 1'b1;
        step(1);
        check("reenable_in_ready", in_ready, 1);
        step(20);
        check("reenable_empty_stays_prime", running, 0);
        push1(16'h0ABC);
        push1(16'h0DEF);
        step(1);
        check("reenable_running", running, 1);

        // Async reset in the middle of a pulse
        wait_av(40);
        #2 reset_n = 1'b0;
        #1;
        check("arst_audio_valid", audio_valid, 0);
        check("arst_pcm_out", pcm_out, 0);
        check("arst_running", running, 0);
        check("arst_underrun", underrun_count, 0);
        check("arst_in_ready", in_ready, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        step(2);
        check("post_arst_running", running, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pcm_tx_scheduler.md
# pcm_tx_scheduler

Paces decoded PCM samples into the SPI sample transmitter at a fixed audio sample rate. A producer (the karaoke mixer) pushes 16-bit samples through a valid/ready handshake into a small FIFO. Once the FIFO is primed, the block emits exactly one sample per sample period as `pcm_out` plus a 1-cycle `audio_valid` pulse. It also handles muting, underrun substitution, and re-priming after sustained starvation.

## Interface

**Parameters**

- `CLK_DIV`, default 3000: clk cycles per sample period (48 MHz / 16 kHz). Must be ≥ 64 so the SPI serializer finishes 16 bits between samples.
- `FIFO_DEPTH`, default 8: sample FIFO entries. Power of 2, ≥ 2.
- `PRIME_LEVEL`, default 4: FIFO occupancy required to start or restart playback. 1 ≤ `PRIME_LEVEL` ≤ `FIFO_DEPTH`.
- `UNDERRUN_REPRIME`, default 4: consecutive underruns that force a return to PRIME. ≥ 1.

**Ports**

- `clk`  input  1  system clock. Reset `reset_n` is asynchronous, active-low; clock is `clk`.
- `reset_n`  input  1  asynchronous active-low reset.
- `enable`  input  1  level; playback requested.
- `mute`  input  1  level; emitted samples forced to 0.
- `in_data`  input  16  producer sample, signed two's complement.
- `in_valid`  input  1  producer sample valid.
- `in_ready`  output  1  FIFO can accept `in_data`.
- `pcm_out`  output  16  sample to the SPI transmitter; held between pulses.
- `audio_valid`  output  1  1-cycle pulse, one per sample period.
- `running`  output  1  high in RUN.
- `underrun_count`  output  8  total underruns, saturating at 255.

## Operation

- **States:** IDLE, PRIME, RUN.
- **IDLE:**
  - FIFO flushed; `in_ready`=0; no pulses.
  - `enable`=1 → PRIME on the next cycle.
- **PRIME:**
  - `in_ready` = ~full; no pulses.
  - Occupancy ≥ `PRIME_LEVEL` → RUN; the period counter is cleared to 0 on the transition.
- **RUN:**
  - The period counter counts 0..`CLK_DIV`-1 and wraps. The tick is the cycle where counter = `CLK_DIV`-1.
  - On a tick with the FIFO not empty: pop the head; `pcm_out` ← (`mute` ? 0 : head); pulse `audio_valid`; clear the consecutive-underrun count.
  - On a tick with the FIFO empty:
    - `pcm_out` ← 0; pulse `audio_valid` anyway, to keep the SPI cadence.
    - `underrun_count` +1, saturating.
    - Consecutive-underrun count +1. If it reaches `UNDERRUN_REPRIME`, go to PRIME after this tick's pulse and clear the consecutive count.
- **enable deasserted** in PRIME or RUN → IDLE next cycle; FIFO flushed; any pulse already registered still completes.
- **Handshake:**
  - A push occurs when `in_valid` & `in_ready`.
  - `in_ready` = (state ≠ IDLE) & ~full, combinational from registered state.
  - When full, `in_ready`=0 even on a pop cycle.
  - Push and pop in the same cycle are both performed; occupancy is unchanged.
- **FIFO:** pointers wrap modulo `FIFO_DEPTH`; occupancy is held in $clog2(`FIFO_DEPTH`)+1 bits. Data is never altered except by mute at emission.
- **Mute:** sampled only at the tick. Muted samples still pop and do not count as underruns.

## Timing

- **Reset values:**
  - state=IDLE; FIFO empty; counter=0; consecutive-underrun count=0.
  - `pcm_out`=0; `audio_valid`=0; `running`=0; `underrun_count`=0; `in_ready`=0.
- **Output registration:** `pcm_out` and `audio_valid` are registered. A tick in cycle T gives `audio_valid`=1 in cycle T+1 only, with the new `pcm_out` valid from T+1.
- **Pulse spacing:** consecutive pulses are exactly `CLK_DIV` cycles apart while in RUN.
- **Start-up latency:** with the PRIME→RUN transition at the edge ending cycle P, the first pulse is in cycle P+`CLK_DIV`+1.
- **running:** registered; equals (state = RUN).
- **Push-to-exit latency:** a push in cycle T is visible to the head/occupancy in T+1.
- **Reset mid-operation:** all state returns to reset values immediately and asynchronously; a pulse in progress is truncated.

## Test plan

All scenarios use `CLK_DIV`=8, `FIFO_DEPTH`=4, `PRIME_LEVEL`=2, `UNDERRUN_REPRIME`=3.

- **Prime and steady run:** `enable`=1; push 0x1111, 0x2222, 0x3333 back-to-back → `running` rises after the 2nd push. Pulses every 8 cycles carry 0x1111, 0x2222, 0x3333 in order. The first pulse comes 9 cycles after the transition.
- **Full FIFO:** hold `in_valid`=1 in RUN with 4 entries → `in_ready`=0 while full. The 5th sample is accepted only on the cycle after a pop; no data is lost or duplicated.
- **Underrun and re-prime:** stop pushing after 2 samples → the 3rd, 4th, and 5th pulses carry 0x0000 and `underrun_count` reaches 3. The FSM then enters PRIME: `running`=0 and no further pulses until 2 new pushes.
- **Mute:** mute during the tick of sample 0x7FFF → pulse carries 0x0000; the next unmuted pulse carries the following FIFO entry; `underrun_count` is unchanged.
- **Disable mid-run:** drop `enable` with 3 entries queued → IDLE next cycle, `in_ready`=0, no further pulses. Re-enable → PRIME with an empty FIFO.
- **Async reset mid-pulse:** assert `reset_n`=0 during an `audio_valid` cycle → `audio_valid`, `pcm_out`, `running`, and `underrun_count` are 0 immediately, and `in_ready`=0.
